// File: rtl/ccx_ic_pkg.sv
// Shared types and constants for the core complex interconnect router.
package ccx_ic_pkg;

    typedef enum logic [1:0] {
        ROUTE_NONE = 2'd0,
        ROUTE_R0   = 2'd1,
        ROUTE_R1   = 2'd2,
        ROUTE_DERR = 2'd3
    } ccx_ic_route_t;

    localparam int CCX_IC_DERR_CW = 8;

endpackage

// File: rtl/core_mem_bus.sv
// Single-cycle-response memory bus between a requestor (REQ side) and a responder (RSP side).
interface core_mem_bus #(
    parameter int AW = 39,
    parameter int DW = 64
);
    logic            req;
    logic            gnt;
    logic [AW-1:0]   addr;
    logic [1:0]      rtype;
    logic            wen;
    logic [DW/8-1:0] strb;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata;
    logic            err;

    modport REQ (output req, addr, rtype, wen, strb, wdata, input gnt, rdata, err);
    modport RSP (input req, addr, rtype, wen, strb, wdata, output gnt, rdata, err);
endinterface

// File: rtl/ccx_ic_addr_decode.sv
// Base/mask address decode to a route; responder 0 wins on overlap.
// A miss becomes ROUTE_DERR with CCX_IC_ROUTER_DECERR_EN, otherwise it defaults to responder 1.
module ccx_ic_addr_decode
    import ccx_ic_pkg::*;
#(
    parameter int            AW      = 39,
    parameter logic [AW-1:0] R0_BASE = 39'h00_0000_0000,
    parameter logic [AW-1:0] R0_MASK = 39'h7F_F000_0000,
    parameter logic [AW-1:0] R1_BASE = 39'h00_1000_0000,
    parameter logic [AW-1:0] R1_MASK = 39'h7F_F000_0000
) (
    input  logic [AW-1:0] i_addr,
    output ccx_ic_route_t o_route
);

    logic w_hit0;
    logic w_hit1;

    assign w_hit0 = ((i_addr & R0_MASK) == R0_BASE);
    assign w_hit1 = ((i_addr & R1_MASK) == R1_BASE);

    // Priority route selection
    always_comb begin
        o_route = ROUTE_NONE;
        if (w_hit0) begin
            o_route = ROUTE_R0;
        end else if (w_hit1) begin
            o_route = ROUTE_R1;
        end else begin
`ifdef CCX_IC_ROUTER_DECERR_EN
            o_route = ROUTE_DERR;
`else
            o_route = ROUTE_R1;
`endif
        end
    end

endmodule

// File: rtl/ccx_ic_router.sv
// One-to-two address-decoded router with a registered response-owner select.
// Optional local decode-error responses: CCX_IC_ROUTER_DECERR_EN.
module ccx_ic_router
    import ccx_ic_pkg::*;
#(
    parameter int            AW      = 39,
    parameter int            DW      = 64,
    parameter logic [AW-1:0] R0_BASE = 39'h00_0000_0000,
    parameter logic [AW-1:0] R0_MASK = 39'h7F_F000_0000,
    parameter logic [AW-1:0] R1_BASE = 39'h00_1000_0000,
    parameter logic [AW-1:0] R1_MASK = 39'h7F_F000_0000
) (
    input  logic                      g_clk,
    input  logic                      g_reset,
    core_mem_bus.RSP                  req,
    core_mem_bus.REQ                  rsp_0,
    core_mem_bus.REQ                  rsp_1,
    output logic [CCX_IC_DERR_CW-1:0] derr_count
);

    ccx_ic_route_t w_route;
    ccx_ic_route_t r_rsel;
    logic          w_gnt;
    logic          w_accept;

    ccx_ic_addr_decode #(
        .AW      (AW),
        .R0_BASE (R0_BASE),
        .R0_MASK (R0_MASK),
        .R1_BASE (R1_BASE),
        .R1_MASK (R1_MASK)
    ) u_decode (
        .i_addr  (req.addr),
        .o_route (w_route)
    );

    assign rsp_0.req   = req.req && (w_route == ROUTE_R0);
    assign rsp_0.addr  = req.addr;
    assign rsp_0.rtype = req.rtype;
    assign rsp_0.wen   = req.wen;
    assign rsp_0.strb  = req.strb;
    assign rsp_0.wdata = req.wdata;

    assign rsp_1.req   = req.req && (w_route == ROUTE_R1);
    assign rsp_1.addr  = req.addr;
    assign rsp_1.rtype = req.rtype;
    assign rsp_1.wen   = req.wen;
    assign rsp_1.strb  = req.strb;
    assign rsp_1.wdata = req.wdata;

    // Grant comes from the selected target; decode errors are granted locally
    always_comb begin
        w_gnt = 1'b0;
        case (w_route)
            ROUTE_R0:   w_gnt = rsp_0.gnt;
            ROUTE_R1:   w_gnt = rsp_1.gnt;
            ROUTE_DERR: w_gnt = 1'b1;
            default:    w_gnt = 1'b0;
        endcase
    end

    assign req.gnt  = w_gnt;
    assign w_accept = req.req && w_gnt;

    // Response owner for the cycle after an accept
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_rsel <= ROUTE_NONE;
        end else if (w_accept) begin
            r_rsel <= w_route;
        end else begin
            r_rsel <= ROUTE_NONE;
        end
    end

    // Response mux from the owning target
    always_comb begin
        req.rdata = {DW{1'b0}};
        req.err   = 1'b0;
        case (r_rsel)
            ROUTE_R0: begin
                req.rdata = rsp_0.rdata;
                req.err   = rsp_0.err;
            end
            ROUTE_R1: begin
                req.rdata = rsp_1.rdata;
                req.err   = rsp_1.err;
            end
            ROUTE_DERR: begin
                req.rdata = {DW{1'b0}};
                req.err   = 1'b1;
            end
            default: begin
                req.rdata = {DW{1'b0}};
                req.err   = 1'b0;
            end
        endcase
    end

`ifdef CCX_IC_ROUTER_DECERR_EN
    logic [CCX_IC_DERR_CW-1:0] r_derr_count;

    // Saturating count of accepted decode errors
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_derr_count <= {CCX_IC_DERR_CW{1'b0}};
        end else if (w_accept && (w_route == ROUTE_DERR) &&
                     (r_derr_count != {CCX_IC_DERR_CW{1'b1}})) begin
            r_derr_count <= r_derr_count + {{(CCX_IC_DERR_CW-1){1'b0}}, 1'b1};
        end else begin
            r_derr_count <= r_derr_count;
        end
    end

    assign derr_count = r_derr_count;
`else
    assign derr_count = {CCX_IC_DERR_CW{1'b0}};
`endif

endmodule

// File: tb/tb_ccx_ic_router.sv
// Directed self-checking bench for ccx_ic_router; expectations follow CCX_IC_ROUTER_DECERR_EN.
module tb_ccx_ic_router;
    import ccx_ic_pkg::*;

    logic       g_clk = 1'b0;
    logic       g_reset;
    logic [7:0] derr_count;
    int         n_checks = 0;
    int         n_fails  = 0;

    core_mem_bus #(.AW(39), .DW(64)) bus_req ();
    core_mem_bus #(.AW(39), .DW(64)) bus_r0 ();
    core_mem_bus #(.AW(39), .DW(64)) bus_r1 ();

    ccx_ic_router dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .req        (bus_req),
        .rsp_0      (bus_r0),
        .rsp_1      (bus_r1),
        .derr_count (derr_count)
    );

    always #5 g_clk = ~g_clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change on the falling edge; accepts happen on the following rising edge
    task automatic next_cyc();
        @(negedge g_clk);
    endtask

    task automatic drive_req(input logic v, input logic [38:0] a, input logic w);
        bus_req.req   = v;
        bus_req.addr  = a;
        bus_req.wen   = w;
        bus_req.wdata = {25'd0, a};
        bus_req.strb  = 8'hFF;
        bus_req.rtype = 2'd0;
    endtask

    task automatic check_route(input string tag, input logic e0, input logic e1, input logic eg);
        #1;
        check_eq({tag, "_r0req"}, {63'd0, bus_r0.req}, {63'd0, e0});
        check_eq({tag, "_r1req"}, {63'd0, bus_r1.req}, {63'd0, e1});
        check_eq({tag, "_gnt"},   {63'd0, bus_req.gnt}, {63'd0, eg});
    endtask

    task automatic check_rsp(input string tag, input logic [63:0] ed, input logic ee);
        #1;
        check_eq({tag, "_rdata"}, bus_req.rdata, ed);
        check_eq({tag, "_err"},   {63'd0, bus_req.err}, {63'd0, ee});
    endtask

    initial begin
        g_reset = 1'b1;
        drive_req(1'b0, 39'd0, 1'b0);
        bus_r0.gnt = 1'b0; bus_r0.rdata = 64'd0; bus_r0.err = 1'b0;
        bus_r1.gnt = 1'b0; bus_r1.rdata = 64'd0; bus_r1.err = 1'b0;

        // Reset state
        #2;
        check_route("rst", 1'b0, 1'b0, 1'b0);
        check_rsp("rst", 64'd0, 1'b0);
        check_eq("rst_derr", {56'd0, derr_count}, 64'd0);
        next_cyc();
        g_reset = 1'b0;

        // Read to responder 0
        next_cyc();
        drive_req(1'b1, 39'h00_0000_0100, 1'b0);
        bus_r0.gnt = 1'b1;
        check_route("rd0", 1'b1, 1'b0, 1'b1);
        next_cyc();
        drive_req(1'b0, 39'd0, 1'b0);
        bus_r0.rdata = 64'hDEAD_BEEF;
        check_rsp("rd0_rsp", 64'hDEAD_BEEF, 1'b0);

        // Write to responder 1 held off for 3 cycles
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            drive_req(1'b1, 39'h00_1000_0008, 1'b1);
            bus_r1.gnt = 1'b0;
            check_route("wr1_wait", 1'b0, 1'b1, 1'b0);
            check_rsp("wr1_wait", 64'd0, 1'b0);
        end
        next_cyc();
        bus_r1.gnt = 1'b1;
        check_route("wr1_gnt", 1'b0, 1'b1, 1'b1);
        next_cyc();
        drive_req(1'b0, 39'd0, 1'b0);
        bus_r1.rdata = 64'h1111_2222;
        check_rsp("wr1_rsp", 64'h1111_2222, 1'b0);

        // Back-to-back R0, R1, R0
        next_cyc();
        drive_req(1'b1, 39'h00_0000_0200, 1'b0);
        bus_r0.gnt = 1'b1; bus_r1.gnt = 1'b1;
        check_route("b2b_c0", 1'b1, 1'b0, 1'b1);
        next_cyc();
        drive_req(1'b1, 39'h00_1000_0000, 1'b0);
        bus_r0.rdata = 64'hA0; bus_r1.rdata = 64'hB0; bus_r1.err = 1'b0;
        check_route("b2b_c1", 1'b0, 1'b1, 1'b1);
        check_rsp("b2b_c1", 64'hA0, 1'b0);
        next_cyc();
        drive_req(1'b1, 39'h00_0FFF_FFF8, 1'b0);
        bus_r0.rdata = 64'hA1; bus_r1.rdata = 64'hB1; bus_r1.err = 1'b1;
        check_route("b2b_c2", 1'b1, 1'b0, 1'b1);
        check_rsp("b2b_c2", 64'hB1, 1'b1);
        next_cyc();
        drive_req(1'b0, 39'd0, 1'b0);
        bus_r0.rdata = 64'hA2; bus_r0.err = 1'b0;
        check_rsp("b2b_c3", 64'hA2, 1'b0);
        bus_r1.err = 1'b0;

        // Region boundaries while idle-granted
        next_cyc();
        drive_req(1'b1, 39'h00_1FFF_FFF8, 1'b0);
        bus_r0.gnt = 1'b0; bus_r1.gnt = 1'b0;
        check_route("bnd_r1top", 1'b0, 1'b1, 1'b0);
        drive_req(1'b1, 39'h00_0FFF_FFF8, 1'b0);
        check_route("bnd_r0top", 1'b1, 1'b0, 1'b0);

        // Miss address
        next_cyc();
        drive_req(1'b1, 39'h00_2000_0000, 1'b0);
        bus_r1.gnt = 1'b1;
        bus_r1.rdata = 64'hC3;
`ifdef CCX_IC_ROUTER_DECERR_EN
        bus_r1.gnt = 1'b0;
        check_route("miss", 1'b0, 1'b0, 1'b1);
        next_cyc();
        drive_req(1'b0, 39'd0, 1'b0);
        check_rsp("miss_rsp", 64'd0, 1'b1);
        check_eq("miss_derr1", {56'd0, derr_count}, 64'd1);
        next_cyc();
        drive_req(1'b1, 39'h40_0000_0000, 1'b0);
        for (int i = 0; i < 300; i++) next_cyc();
        drive_req(1'b0, 39'd0, 1'b0);
        #1;
        check_eq("miss_sat", {56'd0, derr_count}, 64'd255);
`else
        check_route("miss", 1'b0, 1'b1, 1'b1);
        next_cyc();
        drive_req(1'b0, 39'd0, 1'b0);
        check_rsp("miss_rsp", 64'hC3, 1'b0);
        check_eq("miss_derr0", {56'd0, derr_count}, 64'd0);
`endif
        next_cyc();
        next_cyc();

        // Reset mid-response from responder 1
        drive_req(1'b1, 39'h00_1000_0040, 1'b0);
        bus_r1.gnt = 1'b1;
        check_route("rst_c0", 1'b0, 1'b1, 1'b1);
        next_cyc();
        drive_req(1'b0, 39'd0, 1'b0);
        bus_r1.err = 1'b1; bus_r1.rdata = 64'h5A5A;
        check_rsp("rst_pre", 64'h5A5A, 1'b1);
        #2;
        g_reset = 1'b1;
        check_rsp("rst_mid", 64'd0, 1'b0);
        check_eq("rst_mid_derr", {56'd0, derr_count}, 64'd0);
        next_cyc();
        g_reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
